// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store sequencer: runs the data-memory handshake,
// stalls the pipeline, and hands load results to the extension block.
module lsu_mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        stall,
  output logic        misalign,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [2:0]  wb_Regwrite,
  output logic        wb_Regsign,
  output logic [1:0]  wb_addr_10,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic        l_write;
  logic [1:0]  l_size;
  logic        l_sign;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [4:0]  l_rd;

  logic        bad;
  logic        accept;
  logic [3:0]  we_raw;
  logic [31:0] wd_raw;
  logic [2:0]  rw_code;

  always_comb begin
    bad = 1'b0;
    unique case (req_size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = req_addr[0];
      2'b10:   bad = |req_addr[1:0];
      default: bad = 1'b1;
    endcase
  end

  assign accept = (state == S_IDLE) && req_valid && !bad;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (accept) state_n = S_REQ;
      S_REQ: begin
        if (mem_gnt)
          state_n = l_write ? S_DONE : S_WAIT;
      end
      S_WAIT: if (mem_rvalid) state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      misalign <= 1'b0;
      l_write  <= 1'b0;
      l_size   <= 2'b00;
      l_sign   <= 1'b0;
      l_addr   <= '0;
      l_wdata  <= '0;
      l_rd     <= '0;
      wb_data  <= '0;
    end else begin
      state    <= state_n;
      misalign <= (state == S_IDLE) && req_valid && bad;
      if (accept) begin
        l_write <= req_write;
        l_size  <= req_size;
        l_sign  <= req_sign;
        l_addr  <= req_addr;
        l_wdata <= req_wdata;
        l_rd    <= req_rd;
      end
      if (state == S_WAIT && mem_rvalid)
        wb_data <= mem_rdata;
    end
  end

  // Store lane steering from the latched request.
  always_comb begin
    we_raw = 4'b1111;
    wd_raw = l_wdata;
    unique case (1'b1)
      (l_size == 2'b00): begin
        we_raw = 4'b0001 << l_addr[1:0];
        wd_raw = {4{l_wdata[7:0]}};
      end
      (l_size == 2'b01): begin
        we_raw = 4'b0011 << l_addr[1:0];
        wd_raw = {2{l_wdata[15:0]}};
      end
      default: begin
        we_raw = 4'b1111;
        wd_raw = l_wdata;
      end
    endcase
  end

  always_comb begin
    rw_code = 3'b000;
    unique case (l_size)
      2'b00:   rw_code = 3'b001;
      2'b01:   rw_code = 3'b011;
      2'b10:   rw_code = 3'b111;
      default: rw_code = 3'b000;
    endcase
  end

  assign stall = !rst &&
    (accept || state == S_REQ || state == S_WAIT);

  assign mem_req   = (state == S_REQ);
  assign mem_addr  = {l_addr[31:2], 2'b00};
  assign mem_we    = (mem_req && l_write) ? we_raw : 4'b0000;
  assign mem_wdata = wd_raw;

  assign wb_valid    = (state == S_DONE) && !l_write;
  assign wb_Regwrite = wb_valid ? rw_code : 3'b000;
  assign wb_Regsign  = l_sign;
  assign wb_addr_10  = l_addr[1:0];
  assign wb_reg      = l_rd;

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store sequencing controller in the MEM stage. It accepts one load or store per request, runs the data-memory handshake, and stalls the pipeline until the access completes. For loads it captures the read word and drives the write-back extension/alignment controls (Regwrite code, Regsign, addr_10, write_reg) for the downstream load-extension block. Misaligned accesses are flagged and never reach memory.

## Interface
Parameters:
- none; all widths are fixed for RV32.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  MEM stage holds a load/store
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_sign  in  1  1 = sign-extend the load (LB/LH), 0 = zero-extend (LBU/LHU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_rd  in  5  load destination register
- stall  out  1  freeze IF–MEM
- misalign  out  1  one-cycle misaligned-access pulse
- mem_req  out  1  memory request
- mem_gnt  in  1  memory accepted the request
- mem_we  out  4  byte write enables; 0000 for loads
- mem_addr  out  32  {req_addr[31:2], 2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word
- wb_valid  out  1  load result valid for one cycle
- wb_Regwrite  out  3  111 word, 011 half, 001 byte, 000 otherwise
- wb_Regsign  out  1  latched req_sign
- wb_addr_10  out  2  latched req_addr[1:0]
- wb_data  out  32  captured raw read word (unshifted)
- wb_reg  out  5  latched req_rd

## Operation
- The FSM has four states: IDLE, REQ, WAIT, DONE. Its state and all request fields are registered.
- A request is misaligned when req_size is 11, when it is a half access with addr[0]=1, or when it is a word access with addr[1:0]≠00.
- IDLE:
  - If req_valid is high and the request is misaligned, misalign=1 on the next cycle, no memory access is made, and the state stays IDLE.
  - If req_valid is high and the request is aligned, all req_* fields are latched and the state moves to REQ.
- REQ:
  - mem_req=1, decoded from state. mem_addr, mem_we and mem_wdata come from the latched fields and are held stable until mem_gnt.
  - When mem_gnt=1, a store goes to DONE and a load goes to WAIT.
- WAIT:
  - mem_req=0.
  - When mem_rvalid=1, mem_rdata is captured into wb_data and the state moves to DONE.
  - mem_rvalid is ignored in every other state.
- DONE:
  - For loads, wb_valid=1, and wb_Regwrite is set from size: 10→111, 01→011, 00→001.
  - For stores, wb_valid=0 and wb_Regwrite=000.
  - Next state is IDLE unconditionally. req_valid is ignored in DONE.
- stall = (IDLE & req_valid & aligned) | REQ | WAIT. It is 0 in DONE, so the pipeline advances on that edge.
- Store lanes:
  - byte: mem_we = 0001<<addr[1:0], mem_wdata = {4{wdata[7:0]}}
  - half: mem_we = 0011<<addr[1:0], mem_wdata = {2{wdata[15:0]}}
  - word: mem_we = 1111, mem_wdata = wdata
- Reset values: state IDLE; mem_req, mem_we, mem_addr, mem_wdata, wb_* and misalign all 0. stall is forced to 0 while rst=1.
- Reset mid-operation (REQ or WAIT) abandons the access with no write-back. A later mem_rvalid is ignored.

## Timing
- The acceptance cycle is the IDLE cycle with req_valid high.
- Minimum store latency is 2 stall cycles (IDLE, then REQ with gnt), followed by DONE.
- Minimum load latency is 3 stall cycles (IDLE, REQ, WAIT with rvalid), followed by DONE with wb_valid.
- mem_rvalid is never earlier than the cycle after mem_gnt.
- Each wait cycle on gnt or rvalid adds exactly one stall cycle.
- At most one request is outstanding. After DONE there is one IDLE cycle before the next request is accepted.
- misalign is registered: it is high exactly one cycle after the acceptance cycle and does not stall.

## Test plan
- LW at addr 0x100, gnt in the first REQ cycle, rvalid one cycle later with 0xDEADBEEF → stall high for 3 cycles; then wb_valid=1, wb_Regwrite=111, wb_data=0xDEADBEEF, wb_addr_10=00, mem_we=0000.
- LB (sign=1) at addr 0x103 with rd=5 → mem_addr=0x100; in DONE wb_Regwrite=001, wb_Regsign=1, wb_addr_10=11, wb_reg=5.
- SH at addr 0x202 with wdata 0x0000ABCD, gnt delayed 2 cycles → mem_we=1100, mem_wdata=0xABCDABCD, mem_req held 3 cycles, stall 4 cycles, wb_valid never high.
- LW at addr 0x101 → misalign pulses exactly 1 cycle, mem_req stays 0, stall stays 0; LH at addr 0x103 gives the same result.
- Assert rst while in WAIT, then drive rvalid → all outputs return to 0 on the next edge and no wb_valid pulse follows.
- Back-to-back SB then LHU with req_valid held high → the second request is accepted only in the IDLE cycle after DONE, and the first request is not re-issued.
